// File: rtl/board_io_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// board_io_bridge_if : MEM-side level signals between the core and the bridge
// Revision: 1.0
// ============================================================================
interface board_io_bridge_if;
  logic [31:0] display_7_seg_data;
  logic [15:0] switch_in_data;

  modport master (
    output display_7_seg_data,
    input  switch_in_data
  );

  modport slave (
    input  display_7_seg_data,
    output switch_in_data
  );
endinterface
`default_nettype wire

// File: rtl/board_io_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// board_io_bridge : 8-digit 7-segment scanner and 16-bit switch debouncer
// Revision: 1.0
// ============================================================================
module board_io_bridge #(
  parameter int REFRESH_DIV        = 100000,
  parameter int GUARD_CYCLES       = 16,
  parameter int DEBOUNCE_CNT       = 1000000,
  parameter bit SEG_ACTIVE_LOW     = 1'b1,
  parameter bit AN_ACTIVE_LOW      = 1'b1,
  parameter bit LEADING_ZERO_BLANK = 1'b0
) (
  input  wire                  clk,
  input  wire                  reset_n,
  board_io_bridge_if.slave     mem,
  input  wire  [15:0]          sw_raw,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [7:0]           an
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [7:0] c_AN_OFF  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [6:0] c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       c_DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] c_GUARD    = DIV_W'(GUARD_CYCLES);
  localparam logic [DEB_W-1:0] c_DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_digit_idx;
  logic [31:0]      r_shadow;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic [15:0]      r_sync1;
  logic [15:0]      r_sync2;
  logic [15:0]      r_prev;
  logic [15:0]      r_sw;
  logic [DEB_W-1:0] r_deb_cnt;

  logic             w_div_wrap;
  logic             w_deb_tick;
  logic [3:0]       w_nibble;
  logic [31:0]      w_upper;
  logic             w_blank;
  logic [7:0]       w_an_act;
  logic [6:0]       w_seg_act;
  logic [15:0]      w_stable;

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: f_hex7 = 7'h3F;
      4'h1: f_hex7 = 7'h06;
      4'h2: f_hex7 = 7'h5B;
      4'h3: f_hex7 = 7'h4F;
      4'h4: f_hex7 = 7'h66;
      4'h5: f_hex7 = 7'h6D;
      4'h6: f_hex7 = 7'h7D;
      4'h7: f_hex7 = 7'h07;
      4'h8: f_hex7 = 7'h7F;
      4'h9: f_hex7 = 7'h6F;
      4'hA: f_hex7 = 7'h77;
      4'hB: f_hex7 = 7'h7C;
      4'hC: f_hex7 = 7'h39;
      4'hD: f_hex7 = 7'h5E;
      4'hE: f_hex7 = 7'h79;
      default: f_hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    w_div_wrap = (r_div_cnt == c_DIV_LAST);
    w_deb_tick = (r_deb_cnt == c_DEB_LAST);
    w_nibble   = r_shadow[{r_digit_idx, 2'b00} +: 4];
    // Digit k is a leading zero when nibbles k..7 are all zero.
    w_upper    = r_shadow >> {r_digit_idx, 2'b00};
    w_blank    = LEADING_ZERO_BLANK && (r_digit_idx != 3'd0) && (w_upper == 32'h0);
    w_an_act   = ((r_div_cnt >= c_GUARD) && !w_blank) ? (8'h01 << r_digit_idx) : 8'h00;
    w_seg_act  = f_hex7(w_nibble);
    w_stable   = ~(r_sync2 ^ r_prev);
  end

  // Scan state; the shadow only reloads at the frame boundary to avoid tearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 3'd0;
      r_shadow    <= 32'h0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt   <= '0;
        r_digit_idx <= r_digit_idx + 3'd1;
        if (r_digit_idx == 3'd7) begin
          r_shadow <= mem.display_7_seg_data;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= c_AN_OFF;
      r_seg <= c_SEG_OFF;
      r_dp  <= c_DP_OFF;
    end else begin
      r_an  <= AN_ACTIVE_LOW  ? ~w_an_act  : w_an_act;
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_act : w_seg_act;
      r_dp  <= c_DP_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 16'h0;
      r_sync2   <= 16'h0;
      r_prev    <= 16'h0;
      r_sw      <= 16'h0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      if (w_deb_tick) begin
        r_deb_cnt <= '0;
        r_prev    <= r_sync2;
        // A bit is accepted only when it matched at the previous tick too.
        r_sw      <= (r_sync2 & w_stable) | (r_sw & ~w_stable);
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign an                 = r_an;
  assign seg                = r_seg;
  assign dp                 = r_dp;
  assign mem.switch_in_data = r_sw;

endmodule
`default_nettype wire

// File: tb/tb_board_io_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_board_io_bridge : directed cycle-exact checks of scan, blanking, debounce
// Revision: 1.0
// ============================================================================
module tb_board_io_bridge;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  bit          clk_en  = 1'b0;
  logic [15:0] sw_a    = 16'h0;
  logic [15:0] sw_b    = 16'h0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [7:0]  an_a, an_b;

  int          checks = 0;
  int          errors = 0;
  int          n      = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  b_act  = 8'h00;

  board_io_bridge_if ifa ();
  board_io_bridge_if ifb ();

  board_io_bridge #(
    .REFRESH_DIV(8), .GUARD_CYCLES(2), .DEBOUNCE_CNT(4),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LEADING_ZERO_BLANK(1'b0)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .mem(ifa.slave),
    .sw_raw(sw_a), .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  board_io_bridge #(
    .REFRESH_DIV(8), .GUARD_CYCLES(2), .DEBOUNCE_CNT(4),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LEADING_ZERO_BLANK(1'b1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .mem(ifb.slave),
    .sw_raw(sw_b), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Accumulates every anode instance B lights, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) b_act = b_act | ~an_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic goto_edge(input int t);
    while (n < t) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int t;
    ifa.display_7_seg_data = 32'h1234ABCD;
    ifb.display_7_seg_data = 32'h000000A5;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_an_a",  an_a,  8'hFF);
    chk("rst_seg_a", seg_a, 7'h7F);
    chk("rst_dp_a",  dp_a,  1'b1);
    chk("rst_sw_a",  ifa.switch_in_data, 16'h0000);
    chk("rst_an_b",  an_b,  8'hFF);

    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;

    goto_edge(3);
    chk("f1_an_a",  an_a,  8'hFE);
    chk("f1_seg_a", seg_a, 7'h40);
    chk("f1_an_b",  an_b,  8'hFE);
    goto_edge(65);
    chk("f2_guard0_a", an_a, 8'hFF);
    mon_en = 1'b1;
    b_act  = 8'h00;
    goto_edge(66);
    chk("f2_guard1_a", an_a, 8'hFF);
    goto_edge(67);
    chk("f2_d0_an_a",  an_a,  8'hFE);
    chk("f2_d0_seg_a", seg_a, 7'h21);
    chk("f2_dp_a",     dp_a,  1'b1);
    chk("f2_d0_an_b",  an_b,  8'hFE);
    chk("f2_d0_seg_b", seg_b, 7'h12);
    goto_edge(72);
    chk("f2_d0_end_a", an_a, 8'hFE);
    goto_edge(73);
    chk("f2_d1_guard_a", an_a, 8'hFF);
    goto_edge(75);
    chk("f2_d1_an_b",  an_b,  8'hFD);
    chk("f2_d1_seg_b", seg_b, 7'h08);
    goto_edge(83);
    chk("f2_d2_blank_b", an_b,  8'hFF);
    chk("f2_d2_seg_b",   seg_b, 7'h40);
    goto_edge(121);
    chk("f2_d7_guard_a", an_a,  8'hFF);
    chk("f2_d7_gseg_a",  seg_a, 7'h79);
    goto_edge(123);
    chk("f2_d7_an_a",  an_a,  8'h7F);
    chk("f2_d7_seg_a", seg_a, 7'h79);
    ifa.display_7_seg_data = 32'h0;
    ifb.display_7_seg_data = 32'h0;
    goto_edge(129);
    chk("b_act_a5", b_act, 8'h03);
    b_act = 8'h00;
    goto_edge(131);
    chk("f3_d0_an_b",  an_b,  8'hFE);
    chk("f3_d0_seg_b", seg_b, 7'h40);
    goto_edge(153);
    ifa.display_7_seg_data = 32'h88888888;
    goto_edge(163);
    chk("f3_d4_an_a",  an_a,  8'hEF);
    chk("f3_d4_seg_a", seg_a, 7'h40);
    goto_edge(187);
    chk("f3_d7_an_a",  an_a,  8'h7F);
    chk("f3_d7_seg_a", seg_a, 7'h40);
    goto_edge(193);
    chk("f4_guard_a",  an_a,  8'hFF);
    chk("f4_gseg_a",   seg_a, 7'h00);
    chk("b_act_zero",  b_act, 8'h01);
    mon_en = 1'b0;
    goto_edge(195);
    chk("f4_d0_an_a",  an_a,  8'hFE);
    chk("f4_d0_seg_a", seg_a, 7'h00);
    goto_edge(235);
    chk("f4_d5_an_a",  an_a,  8'hDF);
    chk("f4_d5_seg_a", seg_a, 7'h00);

    sw_a = 16'h0008;
    goto_edge(n + 3);
    sw_a = 16'h0000;
    goto_edge(n + 20);
    chk("sw_pulse", ifa.switch_in_data, 16'h0000);
    sw_a = 16'h0008;
    cnt  = 0;
    while ((ifa.switch_in_data[3] !== 1'b1) && (cnt < 20)) begin
      goto_edge(n + 1);
      cnt++;
    end
    chk("sw_lat_in_range", 32'((cnt >= 6) && (cnt <= 10)), 32'd1);
    chk("sw_val", ifa.switch_in_data, 16'h0008);
    chk("sw_b_idle", ifb.switch_in_data, 16'h0000);

    t = ((n / 64) + 1) * 64 + 44;
    goto_edge(t);
    chk("pre_rst_an_a", an_a, 8'hDF);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_an_a",  an_a,  8'hFF);
    chk("mid_rst_seg_a", seg_a, 7'h7F);
    chk("mid_rst_sw_a",  ifa.switch_in_data, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    goto_edge(2);
    chk("post_rst_guard_a", an_a, 8'hFF);
    goto_edge(3);
    chk("post_rst_an_a",  an_a,  8'hFE);
    chk("post_rst_seg_a", seg_a, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
